// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: cause widths, the
// exception NOP word and the fetch FSM encoding.
package inst_fetch_pkg;

  localparam int          CAUSE_W  = 7;
  localparam int          CAUSES_W = 5 * CAUSE_W;
  localparam logic [31:0] NOP_INST = 32'h0340_0000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    HOLD      = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_fetch.sv
// IF stage: fetches pc_i over an addr_ok/data_ok bus (one outstanding) into the IF/ID register.
// Latency: best case addr_ok then data_ok, ID loads on the edge after data_ok; stalls via stallreq_o.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_i,
  input  logic                inst_en_i,
  input  logic [4:0]          is_exception_i,
  input  logic [CAUSES_W-1:0] exception_cause_i,
  input  logic [5:0]          pause,
  input  logic                flush_i,
  input  logic                branch_flush_i,
  output logic                inst_req_o,
  output logic [31:0]         inst_addr_o,
  input  logic                inst_addr_ok_i,
  input  logic                inst_data_ok_i,
  input  logic [31:0]         inst_rdata_i,
  output logic                stallreq_o,
  output logic                id_valid_o,
  output logic [31:0]         id_pc_o,
  output logic [31:0]         id_inst_o,
  output logic [4:0]          id_is_exception_o,
  output logic [CAUSES_W-1:0] id_exception_cause_o
);

  if_state_e           state_q;
  logic                discard_q;
  logic [31:0]         buf_pc_q;
  logic [31:0]         buf_inst_q;
  logic [4:0]          buf_exc_q;
  logic [CAUSES_W-1:0] buf_cause_q;
  logic                id_valid_q;
  logic [31:0]         id_pc_q;
  logic [31:0]         id_inst_q;
  logic [4:0]          id_exc_q;
  logic [CAUSES_W-1:0] id_cause_q;

  logic exc, flush, req, accept, fetch_done;
  logic unused_pause;

  assign unused_pause = ^pause[5:2];

  assign exc    = |is_exception_i;
  // A branch flush is ignored while the PC stage is stalled: the branch will be re-presented.
  assign flush  = flush_i | (branch_flush_i & ~pause[0]);
  assign req    = (state_q == IDLE) & inst_en_i & ~exc & ~discard_q & ~flush_i & ~rst;
  assign accept = req & inst_addr_ok_i;

  assign fetch_done = ((state_q == WAIT_DATA) & inst_data_ok_i & ~discard_q)
                    | (state_q == HOLD)
                    | ((state_q == IDLE) & inst_en_i & exc);

  assign inst_req_o  = req;
  assign inst_addr_o = pc_i;
  assign stallreq_o  = inst_en_i & ~fetch_done & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      discard_q   <= 1'b0;
      buf_pc_q    <= '0;
      buf_inst_q  <= NOP_INST;
      buf_exc_q   <= '0;
      buf_cause_q <= '0;
      id_valid_q  <= 1'b0;
      id_pc_q     <= '0;
      id_inst_q   <= NOP_INST;
      id_exc_q    <= '0;
      id_cause_q  <= '0;
    end else begin
      if (discard_q && inst_data_ok_i) discard_q <= 1'b0;
      if (accept) begin
        buf_pc_q    <= pc_i;
        buf_exc_q   <= is_exception_i;
        buf_cause_q <= exception_cause_i;
      end

      if (flush) begin
        id_valid_q <= 1'b0;
        state_q    <= IDLE;
        // Anything still owed by memory must be swallowed when it returns.
        if (((state_q == WAIT_DATA) && !inst_data_ok_i) || accept) discard_q <= 1'b1;
      end else if (pause[1]) begin
        if ((state_q == WAIT_DATA) && fetch_done) begin
          buf_inst_q <= inst_rdata_i;
          state_q    <= HOLD;
        end else if (accept) begin
          state_q <= WAIT_DATA;
        end
      end else if (fetch_done) begin
        id_valid_q <= 1'b1;
        state_q    <= IDLE;
        case (state_q)
          HOLD: begin
            id_pc_q    <= buf_pc_q;
            id_inst_q  <= buf_inst_q;
            id_exc_q   <= buf_exc_q;
            id_cause_q <= buf_cause_q;
          end
          WAIT_DATA: begin
            id_pc_q    <= buf_pc_q;
            id_inst_q  <= inst_rdata_i;
            id_exc_q   <= buf_exc_q;
            id_cause_q <= buf_cause_q;
          end
          default: begin
            id_pc_q    <= pc_i;
            id_inst_q  <= NOP_INST;
            id_exc_q   <= is_exception_i;
            id_cause_q <= exception_cause_i;
          end
        endcase
      end else begin
        id_valid_q <= 1'b0;
        if (accept) state_q <= WAIT_DATA;
      end
    end
  end

  assign id_valid_o           = id_valid_q;
  assign id_pc_o              = id_pc_q;
  assign id_inst_o            = id_inst_q;
  assign id_is_exception_o    = id_exc_q;
  assign id_exception_cause_o = id_cause_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: combinational outputs checked inline, IF/ID
// transfers checked by a scoreboard monitor against hand-computed expectations.
module tb_inst_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  exc;
    logic [34:0] cause;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        inst_en_i;
  logic [4:0]  is_exception_i;
  logic [34:0] exception_cause_i;
  logic [5:0]  pause;
  logic        flush_i;
  logic        branch_flush_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        stallreq_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [4:0]  id_is_exception_o;
  logic [34:0] id_exception_cause_o;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [5:0] pause_e = '0;
  logic       rst_e   = 1'b1;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc_i                (pc_i),
    .inst_en_i           (inst_en_i),
    .is_exception_i      (is_exception_i),
    .exception_cause_i   (exception_cause_i),
    .pause               (pause),
    .flush_i             (flush_i),
    .branch_flush_i      (branch_flush_i),
    .inst_req_o          (inst_req_o),
    .inst_addr_o         (inst_addr_o),
    .inst_addr_ok_i      (inst_addr_ok_i),
    .inst_data_ok_i      (inst_data_ok_i),
    .inst_rdata_i        (inst_rdata_i),
    .stallreq_o          (stallreq_o),
    .id_valid_o          (id_valid_o),
    .id_pc_o             (id_pc_o),
    .id_inst_o           (id_inst_o),
    .id_is_exception_o   (id_is_exception_o),
    .id_exception_cause_o(id_exception_cause_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Inputs seen by the DUT at each edge, so the monitor knows whether ID was loaded or held.
  always @(posedge clk) begin
    pause_e <= pause;
    rst_e   <= rst;
  end

  always @(negedge clk) begin
    if (!rst_e && !pause_e[1] && id_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_id_valid", {63'd0, id_valid_o}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("id_pc",    {32'd0, id_pc_o},              {32'd0, e.pc});
        chk("id_inst",  {32'd0, id_inst_o},            {32'd0, e.inst});
        chk("id_exc",   {59'd0, id_is_exception_o},    {59'd0, e.exc});
        chk("id_cause", {29'd0, id_exception_cause_o}, {29'd0, e.cause});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_i = 32'h100; inst_en_i = 1'b1; is_exception_i = '0;
    exception_cause_i = '0; pause = '0; flush_i = 1'b0; branch_flush_i = 1'b0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;

    cyc();
    cyc();
    chk("rst_req",      {63'd0, inst_req_o}, 64'd0);
    chk("rst_id_valid", {63'd0, id_valid_o}, 64'd0);
    chk("rst_id_pc",    {32'd0, id_pc_o},    64'd0);
    chk("rst_id_inst",  {32'd0, id_inst_o},  64'h0340_0000);
    chk("rst_id_exc",   {59'd0, id_is_exception_o}, 64'd0);

    // Basic fetch at 0x100: addr_ok with the request, data_ok next cycle.
    rst = 1'b0; inst_addr_ok_i = 1'b1;
    #1;
    chk("t1_req",   {63'd0, inst_req_o},  64'd1);
    chk("t1_addr",  {32'd0, inst_addr_o}, 64'h100);
    chk("t1_stall", {63'd0, stallreq_o},  64'd1);
    cyc();
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'h0280_0404;
    #1;
    chk("t1_req_wait",   {63'd0, inst_req_o}, 64'd0);
    chk("t1_stall_data", {63'd0, stallreq_o}, 64'd0);
    exp_q.push_back('{pc: 32'h100, inst: 32'h0280_0404, exc: 5'd0, cause: 35'd0});
    cyc();

    // Exception-tagged PC: no bus request, NOP delivered with flags.
    inst_data_ok_i = 1'b0; pc_i = 32'h102; is_exception_i = 5'b01000;
    exception_cause_i = 35'h4_0000_000A;
    #1;
    chk("t2_req",   {63'd0, inst_req_o}, 64'd0);
    chk("t2_stall", {63'd0, stallreq_o}, 64'd0);
    exp_q.push_back('{pc: 32'h102, inst: 32'h0340_0000, exc: 5'b01000, cause: 35'h4_0000_000A});
    cyc();

    // Flush while waiting for data: late response must be swallowed.
    is_exception_i = '0; exception_cause_i = '0; pc_i = 32'h200; inst_addr_ok_i = 1'b1;
    #1;
    chk("t3_req", {63'd0, inst_req_o}, 64'd1);
    cyc();
    inst_addr_ok_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("t3_stall_flush", {63'd0, stallreq_o}, 64'd0);
    cyc();
    flush_i = 1'b0; pc_i = 32'h300;
    #1;
    chk("t3_req_discard", {63'd0, inst_req_o}, 64'd0);
    chk("t3_stall",       {63'd0, stallreq_o}, 64'd1);
    cyc();
    inst_data_ok_i = 1'b1; inst_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("t3_req_drop", {63'd0, inst_req_o}, 64'd0);
    cyc();
    inst_data_ok_i = 1'b0; inst_addr_ok_i = 1'b1;
    #1;
    chk("t3_req_new",  {63'd0, inst_req_o},  64'd1);
    chk("t3_addr_new", {32'd0, inst_addr_o}, 64'h300);
    cyc();

    // ID stalled when data arrives: word is buffered, released when pause drops.
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'h1111_2222; pause = 6'b000011;
    cyc();
    inst_data_ok_i = 1'b0;
    #1;
    chk("t4_hold_stall", {63'd0, stallreq_o}, 64'd0);
    chk("t4_hold_req",   {63'd0, inst_req_o}, 64'd0);
    chk("t4_hold_pc",    {32'd0, id_pc_o},    64'h102);
    chk("t4_hold_valid", {63'd0, id_valid_o}, 64'd0);
    cyc();
    pause = 6'b000000;
    exp_q.push_back('{pc: 32'h300, inst: 32'h1111_2222, exc: 5'd0, cause: 35'd0});
    cyc();

    // addr_ok withheld: request and address must stay put.
    pc_i = 32'h400;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_req",   {63'd0, inst_req_o},  64'd1);
      chk("t5_addr",  {32'd0, inst_addr_o}, 64'h400);
      chk("t5_stall", {63'd0, stallreq_o},  64'd1);
      cyc();
    end
    inst_addr_ok_i = 1'b1;
    cyc();

    // Taken branch coincident with data_ok: wrong-path word dropped, no discard left behind.
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'hBADB_AD00; branch_flush_i = 1'b1;
    #1;
    chk("t6_stall", {63'd0, stallreq_o}, 64'd0);
    cyc();
    inst_data_ok_i = 1'b0; branch_flush_i = 1'b0; pc_i = 32'h500;
    #1;
    chk("t6_req_after",   {63'd0, inst_req_o}, 64'd1);
    chk("t6_valid_after", {63'd0, id_valid_o}, 64'd0);
    inst_en_i = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
